ctrl_decode_queue: RTL
======================

Name: ctrl_decode_queue

Overview:
Registered successor to the combinational control-word generator. Decodes each incoming RV32I instruction (plus optional RV32M) into an rv32i_control_word and buffers it in a DEPTH-entry FIFO between fetch and execute, with valid/ready handshakes on both sides. Adds the following over the combinational generator: flush, rd==x0 write suppression, illegal-instruction flagging, M-extension tagging, and occupancy reporting.

Parameters:
DEPTH, 4, number of queued decoded words; power of two, >= 2
EN_MEXT, 1, 1 = decode RV32M (op_reg with funct7=0000001); 0 = treat it as illegal

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  discard all queued entries and any same-cycle enqueue
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept; equals (count < DEPTH); registered-derived, no combinational path from out_ready
in_instr  in  32  raw instruction
in_pc  in  32  PC of in_instr
out_valid  out  1  head entry valid; equals (count != 0)
out_ready  in  1  execute consumes the head entry
out_word  out  rv32i_control_word  decoded control word of the head entry
out_illegal  out  1  head entry is an illegal instruction
out_mext  out  1  head entry is an RV32M op; the M operation is out_word.funct3
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=0, asynchronous): count=0, pointers=0, out_valid=0, in_ready=1, out_word all-zero, out_illegal=0, out_mext=0.
- Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready && !flush. Both may occur in one cycle; count is then unchanged.
- Full: in_ready=0 and in_instr is ignored, even if out_ready=1 in the same cycle (no bypass).
- Latency: an instruction accepted in cycle N is visible at the head no earlier than N+1. There is no fall-through when empty.
- When empty, out_word, out_illegal and out_mext are driven to zero, never stale data.
- Pointers are log2(DEPTH) bits and wrap naturally. count saturates structurally at DEPTH.
- flush=1: at the next edge count=0 and both pointers=0. Any push or pop in that cycle is discarded. flush has priority over everything except rst.
- Decode is done combinationally on in_instr/in_pc before storage. The stored fields are: opcode, aluop, load_regfile, regfilemux_sel, pcmux_sel, alumux1/2_sel, cmpmux_sel, mem_read, mem_write, rd, funct3, funct7, pc.
- Decode mapping:
  - op_br: pc_out + b_imm, add.
  - op_load: add, mem_read=1, load_regfile=1, regfilemux by funct3 (lw/lh/lhu/lb/lbu).
  - op_store: s_imm, add, mem_write=1.
  - op_imm/op_reg: aluop=funct3, except sr selects srl/sra by funct7[5] and op_reg add selects add/sub by funct7[5]. slt/sltu route br_en to the regfile. op_reg uses rs2_out for alumux2.
  - op_lui: u_imm.
  - op_auipc: pc_out + u_imm.
  - op_jal: pc_out + j_imm, pcmux alu_out, regfile pc_plus4.
  - op_jalr: rs1 + i_imm, pcmux alu_mod2, regfile pc_plus4.
- New rule, rd==0: load_regfile forced to 0 for every opcode.
- New rule, M-extension: op_reg with funct7=0000001 and EN_MEXT=1 gives mext=1, load_regfile=1, regfilemux alu_out, aluop=alu_add (ignored by the ALU when mext=1).
- Illegal cases:
  - unknown opcode;
  - op_reg funct7 not in {0000000, 0100000, and 0000001 when EN_MEXT=1};
  - funct7=0100000 with op_reg funct3 other than add/sr;
  - op_imm shift (funct3 sll/sr) with funct7 other than 0000000 or (sr, 0100000);
  - op_load funct3 in {011, 110, 111}; op_store funct3 > 010;
  - op_br funct3 in {010, 011}; op_jalr funct3 != 000.
- Illegal entries are enqueued with illegal=1 and load_regfile=mem_read=mem_write=0, pcmux pc_plus4, other fields as decoded.
- Reset asserted mid-operation clears all state immediately, with no wait for a clock edge.

Test Plan:
1. Reset then push 0x00500093 (addi x1,x0,5) at PC 0x60 with out_ready=0 -> next cycle out_valid=1, count=1, opcode op_imm, aluop add, alumux2 i_imm, load_regfile=1, rd=1, pc=0x60, illegal=0.
2. Push 0x402081B3 (sub x3,x1,x2), then 0x027302B3 (mul x5,x6,x7), with EN_MEXT=1 -> first aluop sub with alumux2 rs2_out; second mext=1, funct3=000, rd=5, load_regfile=1. Repeat with EN_MEXT=0 -> second entry illegal=1, load_regfile=0.
3. Push 0x00000013 (addi x0,x0,0) and 0x000000EF vs 0x0000006F (jal x1 / jal x0) -> load_regfile=0 for rd=0 entries, 1 for jal x1 with regfile pc_plus4.
4. Push DEPTH=4 words with out_ready=0 -> count=4, in_ready=0; a 5th word with in_valid=1 and out_ready=1 is not accepted that cycle, and pop order matches push order.
5. Queue holding 3 entries; assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_word all-zero, in_ready=1.
6. Push 0xFFFFFFFF, then drop rst low asynchronously between edges while count=2 -> out_illegal=1 before reset; all outputs return to reset values immediately on rst=0.

Source files
------------

// File: rtl/ctrl_decode_queue.sv
// Decodes RV32I/RV32M instructions into control words and buffers them in a
// DEPTH-entry FIFO with valid/ready on both sides, flush and occupancy count.
// out_word layout (MSB..LSB): opcode[7] aluop[3] load_regfile regfilemux_sel[4]
// pcmux_sel[2] alumux1_sel alumux2_sel[3] cmpmux_sel mem_read mem_write rd[5]
// funct3[3] funct7[7] pc[32]
module ctrl_decode_queue #(
  parameter int DEPTH   = 4,
  parameter bit EN_MEXT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [70:0]              out_word,
  output logic                     out_illegal,
  output logic                     out_mext,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 73;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL  = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SRA = 3'd2, ALU_SUB = 3'd3, ALU_SRL = 3'd5;
  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3, F3_SR = 3'd5;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MUL = 7'b0000001;
  localparam logic [3:0] RF_ALU = 4'd0, RF_BR = 4'd1, RF_U = 4'd2, RF_LW = 4'd3, RF_PC4 = 4'd4,
                         RF_LB = 4'd5, RF_LBU = 4'd6, RF_LH = 4'd7, RF_LHU = 4'd8;
  localparam logic [1:0] PC_PLUS4 = 2'd0, PC_ALU = 2'd1, PC_MOD2 = 2'd2;
  localparam logic       AM1_RS1 = 1'b0, AM1_PC = 1'b1;
  localparam logic [2:0] AM2_I = 3'd0, AM2_U = 3'd1, AM2_B = 3'd2, AM2_S = 3'd3, AM2_J = 3'd4,
                         AM2_RS2 = 3'd5;
  localparam logic       CMP_RS2 = 1'b0, CMP_I = 1'b1;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       unused_fields;

  assign opcode        = in_instr[6:0];
  assign rd            = in_instr[11:7];
  assign funct3        = in_instr[14:12];
  assign funct7        = in_instr[31:25];
  assign unused_fields = ^in_instr[24:15];

  logic [2:0] d_aluop, d_am2;
  logic [3:0] d_rfm;
  logic [1:0] d_pcm;
  logic       d_lr, d_am1, d_cmp, d_mr, d_mw, d_ill, d_mext;

  always_comb begin
    d_aluop = funct3;
    d_lr    = 1'b0;
    d_rfm   = RF_ALU;
    d_pcm   = PC_PLUS4;
    d_am1   = AM1_RS1;
    d_am2   = AM2_I;
    d_cmp   = CMP_RS2;
    d_mr    = 1'b0;
    d_mw    = 1'b0;
    d_ill   = 1'b0;
    d_mext  = 1'b0;
    case (opcode)
      OP_LUI: begin d_lr = 1'b1; d_rfm = RF_U; end
      OP_AUIPC: begin d_am1 = AM1_PC; d_am2 = AM2_U; d_aluop = ALU_ADD; d_lr = 1'b1; end
      OP_JAL: begin
        d_am1 = AM1_PC; d_am2 = AM2_J; d_aluop = ALU_ADD;
        d_pcm = PC_ALU; d_lr = 1'b1; d_rfm = RF_PC4;
      end
      OP_JALR: begin
        d_aluop = ALU_ADD; d_pcm = PC_MOD2; d_lr = 1'b1; d_rfm = RF_PC4;
        d_ill = (funct3 != 3'd0);
      end
      OP_BR: begin
        d_am1 = AM1_PC; d_am2 = AM2_B; d_aluop = ALU_ADD;
        d_ill = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OP_LOAD: begin
        d_aluop = ALU_ADD; d_mr = 1'b1; d_lr = 1'b1;
        case (funct3)
          3'd0: d_rfm = RF_LB;
          3'd1: d_rfm = RF_LH;
          3'd4: d_rfm = RF_LBU;
          3'd5: d_rfm = RF_LHU;
          default: d_rfm = RF_LW;
        endcase
        d_ill = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OP_STORE: begin
        d_am2 = AM2_S; d_aluop = ALU_ADD; d_mw = 1'b1;
        d_ill = (funct3 > 3'd2);
      end
      OP_IMM: begin
        d_lr = 1'b1;
        case (funct3)
          F3_SLT, F3_SLTU: begin d_cmp = CMP_I; d_rfm = RF_BR; end
          F3_SLL: d_ill = (funct7 != F7_BASE);
          F3_SR: begin
            d_aluop = funct7[5] ? ALU_SRA : ALU_SRL;
            d_ill   = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
          default: ;
        endcase
      end
      OP_REG: begin
        d_am2 = AM2_RS2; d_lr = 1'b1;
        case (funct3)
          F3_ADD: if (funct7[5]) d_aluop = ALU_SUB;
          F3_SR: d_aluop = funct7[5] ? ALU_SRA : ALU_SRL;
          F3_SLT, F3_SLTU: d_rfm = RF_BR;
          default: ;
        endcase
        // M ops carry their operation in funct3; the ALU ignores aluop for them
        if (funct7 == F7_MUL) begin
          if (EN_MEXT) begin
            d_mext = 1'b1; d_aluop = ALU_ADD; d_rfm = RF_ALU;
          end else begin
            d_ill = 1'b1;
          end
        end else if (funct7 == F7_ALT) begin
          d_ill = (funct3 != F3_ADD) && (funct3 != F3_SR);
        end else if (funct7 != F7_BASE) begin
          d_ill = 1'b1;
        end
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_lr  = 1'b0;
      d_mr  = 1'b0;
      d_mw  = 1'b0;
      d_pcm = PC_PLUS4;
    end
    if (rd == 5'd0) d_lr = 1'b0;
  end

  logic [ENTRY_W-1:0] d_entry;
  assign d_entry = {opcode, d_aluop, d_lr, d_rfm, d_pcm, d_am1, d_am2, d_cmp, d_mr, d_mw,
                    rd, funct3, funct7, in_pc, d_ill, d_mext};

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               push, pop;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= d_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Empty queue shows zeros rather than whatever the head slot last held
  logic [ENTRY_W-1:0] head;
  assign head        = out_valid ? mem[rd_ptr] : '0;
  assign out_word    = head[ENTRY_W-1:2];
  assign out_illegal = head[1];
  assign out_mext    = head[0];

endmodule
